// File: rtl/rtc_bus_scheduler.sv
// rtl/rtc_bus_scheduler.sv - RTC multiplexed bus owner arbitrating adjust writes and the periodic time read sweep
// Every bus access is an address phase and a data phase, each followed by a fixed-length strobe-high interval.
module rtc_bus_scheduler #(
  parameter int T_PULSE   = 10,
  parameter int T_REFRESH = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       rd_valid,
  output logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam int PW = (T_PULSE > 1) ? $clog2(T_PULSE) : 1;
  localparam int RW = (T_REFRESH > 1) ? $clog2(T_REFRESH) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(T_PULSE - 1);
  localparam logic [RW-1:0] REF_LAST   = RW'(T_REFRESH - 1);
  localparam logic [7:0]    SWEEP_BASE = 8'h21;

  typedef enum logic [2:0] {S_IDLE, S_ADR, S_GAP, S_DAT, S_REC} state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [RW-1:0] ref_cnt;
  logic          ref_pend;
  logic          wp_valid;
  logic [7:0]    wp_addr;
  logic [7:0]    wp_data;
  logic          act_wr;
  logic [7:0]    act_addr;
  logic [7:0]    act_data;
  logic [1:0]    sweep_idx;

  logic phase_last;
  logic ref_wrap;
  logic start;

  assign phase_last = (phase == PHASE_LAST);
  assign ref_wrap   = (ref_cnt == REF_LAST);
  assign start      = (state == S_IDLE) && (wp_valid || ref_pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= '0;
      ref_cnt   <= '0;
      ref_pend  <= 1'b1;
      wp_valid  <= 1'b0;
      wp_addr   <= 8'h00;
      wp_data   <= 8'h00;
      act_wr    <= 1'b0;
      act_addr  <= 8'h00;
      act_data  <= 8'h00;
      sweep_idx <= 2'd0;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_addr   <= 8'h00;
      rd_data   <= 8'h00;
      busy      <= 1'b0;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      a_d       <= 1'b1;
      ad_out    <= 8'h00;
      ad_oe     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      ref_cnt  <= ref_wrap ? '0 : ref_cnt + 1'b1;

      // A wrap while a sweep is still owed is simply absorbed.
      if (ref_wrap) begin
        ref_pend <= 1'b1;
      end else if (start && !wp_valid) begin
        ref_pend <= 1'b0;
      end

      // Last strobe wins; a strobe coinciding with a grant becomes the next pending entry.
      if (wr_req) begin
        wp_valid <= 1'b1;
        wp_addr  <= wr_addr;
        wp_data  <= wr_data;
      end else if (start && wp_valid) begin
        wp_valid <= 1'b0;
      end

      if (state != S_IDLE) begin
        phase <= phase_last ? '0 : phase + 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ADR;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            wr_n      <= 1'b0;
            a_d       <= 1'b0;
            ad_oe     <= 1'b1;
            act_wr    <= wp_valid;
            act_addr  <= wp_valid ? wp_addr : SWEEP_BASE;
            act_data  <= wp_data;
            ad_out    <= wp_valid ? wp_addr : SWEEP_BASE;
            sweep_idx <= 2'd0;
          end
        end
        S_ADR: begin
          if (phase_last) begin
            state <= S_GAP;
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
            ad_oe <= 1'b0;
            a_d   <= 1'b1;
          end
        end
        S_GAP: begin
          if (phase_last) begin
            state <= S_DAT;
            cs_n  <= 1'b0;
            if (act_wr) begin
              wr_n   <= 1'b0;
              ad_oe  <= 1'b1;
              ad_out <= act_data;
            end else begin
              rd_n <= 1'b0;
            end
          end
        end
        S_DAT: begin
          if (phase_last) begin
            state <= S_REC;
            cs_n  <= 1'b1;
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            ad_oe <= 1'b0;
            if (act_wr) begin
              wr_ack <= 1'b1;
            end else begin
              rd_valid <= 1'b1;
              rd_addr  <= act_addr;
              rd_data  <= ad_in;
            end
          end
        end
        S_REC: begin
          if (phase_last) begin
            // A sweep chains its three reads without returning to IDLE, so no write can cut in.
            if (!act_wr && sweep_idx != 2'd2) begin
              state     <= S_ADR;
              sweep_idx <= sweep_idx + 2'd1;
              act_addr  <= act_addr + 8'd1;
              ad_out    <= act_addr + 8'd1;
              cs_n      <= 1'b0;
              wr_n      <= 1'b0;
              a_d       <= 1'b0;
              ad_oe     <= 1'b1;
            end else begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              sweep_idx <= 2'd0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
